// File: rtl/trb_mem_scheduler_pkg.sv
// Shared types and constants for the trace-memory time-division scheduler.
package trb_mem_scheduler_pkg;

    localparam int TRB_DEPTH     = 16;
    localparam int TRB_WIDTH     = 8;
    localparam int TRB_FRAME_LEN = 4;

    typedef enum logic [1:0] {
        SCH_CLEAR = 2'd0,
        SCH_RUN   = 2'd1,
        SCH_LOCK  = 2'd2
    } sched_state_t;

    typedef bit [1:0] sched_phase_t;

    // Slot owners inside one frame
    localparam sched_phase_t PH_LOG_RD   = 2'd0;
    localparam sched_phase_t PH_LOG_WR   = 2'd1;
    localparam sched_phase_t PH_HOST     = 2'd2;
    localparam sched_phase_t PH_HOST_RSP = 2'd3;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/trb_mem_scheduler_if.sv
// Logger, host and memory-macro signals of the trace-memory scheduler.
// slave = scheduler side, master = surrounding logic (logger, host, macro).
interface trb_mem_scheduler_if
    import trb_mem_scheduler_pkg::*;
#(
    parameter int DEPTH = TRB_DEPTH,
    parameter int WIDTH = TRB_WIDTH
);
    localparam int AW = $clog2(DEPTH);

    // logger
    logic             log_write;
    logic [AW-1:0]    log_wptr;
    logic [WIDTH-1:0] log_wdata;
    logic [AW-1:0]    log_rptr;
    logic [WIDTH-1:0] log_rdata;
    // host
    logic             host_req;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [WIDTH-1:0] host_wdata;
    logic             host_ack;
    logic             host_err;
    logic [WIDTH-1:0] host_rdata;
    // memory macro
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  log_write, log_wptr, log_wdata, log_rptr,
        output log_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_err, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output log_write, log_wptr, log_wdata, log_rptr,
        input  log_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_err, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/trb_mem_scheduler.sv
// Time-division scheduler for the single-port trace memory. A fixed 4-cycle
// frame gives ph0 to logger reads, ph1 to logger writes / zero-fill, ph2 to
// the host and ph3 to the host response. Mode changes happen only at frame end.
module trb_mem_scheduler
    import trb_mem_scheduler_pkg::*;
#(
    parameter int DEPTH          = TRB_DEPTH,
    parameter int WIDTH          = TRB_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic host_lock_i,
    input  logic stream_en_i,
    output logic busy_o,
    output logic locked_o,
    output logic rw_turn_o,
    output logic write_allow_o,
    output logic read_allow_o,
    trb_mem_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam sched_state_t RESET_STATE = CLEAR_ON_RESET ? SCH_CLEAR : SCH_RUN;

    sched_phase_t     ph_q;
    sched_state_t     state_q, state_d;
    logic [AW-1:0]    clr_addr_q;
    logic             clr_done_q;   // last word of the sweep written this frame
    logic             clr_req_q;    // CLEAR_I seen since the last frame end
    logic             pend_q, pend_we_q;
    logic [AW-1:0]    pend_addr_q;
    logic [WIDTH-1:0] pend_wdata_q;
    logic             iss_q, iss_rd_q, iss_err_q;
    logic             ack_q, err_q;
    logic [WIDTH-1:0] rdata_q;

    logic             frame_end, host_issue;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    assign frame_end  = (ph_q == PH_HOST_RSP);
    assign host_issue = (ph_q == PH_HOST) && pend_q && (state_q != SCH_CLEAR);

    // Free-running frame phase; wraps 3 -> 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ph_q <= PH_LOG_RD;
        else         ph_q <= ph_q + sched_phase_t'(1);
    end

    // Mode register, only updated at frame end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RESET_STATE;
        else         state_q <= state_d;
    end

    // Next mode: a pending clear beats any lock change
    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            case (state_q)
                SCH_CLEAR: if (clr_done_q) state_d = SCH_RUN;
                SCH_RUN: begin
                    if (clr_req_q || clear_i) state_d = SCH_CLEAR;
                    else if (host_lock_i)     state_d = SCH_LOCK;
                end
                SCH_LOCK: begin
                    if (clr_req_q || clear_i) state_d = SCH_CLEAR;
                    else if (!host_lock_i)    state_d = SCH_RUN;
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // Zero-fill sweep pointer and sticky clear request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
            clr_req_q  <= 1'b0;
        end else begin
            if (state_q == SCH_CLEAR && ph_q == PH_LOG_WR) begin
                clr_addr_q <= clr_addr_q + 1'b1;   // wraps to 0 after the last word
                if (clr_addr_q == AW'(DEPTH - 1)) clr_done_q <= 1'b1;
            end
            if (frame_end)                               clr_done_q <= 1'b0;
            if (frame_end)                               clr_req_q  <= 1'b0;
            else if (clear_i && state_q != SCH_CLEAR)    clr_req_q  <= 1'b1;
        end
    end

    // Host request capture, ph2 issue, ph3 completion (ack visible in next ph0)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            iss_q        <= 1'b0;
            iss_rd_q     <= 1'b0;
            iss_err_q    <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (!pend_q && bus.host_req) begin
                pend_q       <= 1'b1;
                pend_we_q    <= bus.host_we;
                pend_addr_q  <= bus.host_addr;
                pend_wdata_q <= bus.host_wdata;
            end
            if (host_issue) begin
                iss_q     <= 1'b1;
                iss_rd_q  <= !pend_we_q;
                iss_err_q <= pend_we_q && (state_q != SCH_LOCK);
            end
            if (iss_q) begin
                iss_q  <= 1'b0;
                pend_q <= 1'b0;
                ack_q  <= 1'b1;
                err_q  <= iss_err_q;
                if (iss_rd_q) rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Memory port mux: which client owns the macro in the current phase
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rw_turn_o = 1'b0;
        case (ph_q)
            PH_LOG_RD: begin
                if (state_q != SCH_CLEAR && stream_en_i) begin
                    mem_en   = 1'b1;
                    mem_addr = bus.log_rptr;
                end
            end
            PH_LOG_WR: begin
                rw_turn_o = (state_q != SCH_CLEAR);
                if (state_q == SCH_CLEAR) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = clr_addr_q;
                end else if (state_q == SCH_RUN && bus.log_write) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = bus.log_wptr;
                    mem_wdata = bus.log_wdata;
                end
            end
            PH_HOST: begin
                if (host_issue) begin
                    mem_addr = pend_addr_q;
                    if (!pend_we_q) begin
                        mem_en = 1'b1;
                    end else if (state_q == SCH_LOCK) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_wdata = pend_wdata_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.log_rdata  = bus.mem_rdata;
    assign bus.host_ack   = ack_q;
    assign bus.host_err   = err_q;
    assign bus.host_rdata = rdata_q;

    // BUSY reflects CLEAR, which is also the reset mode when CLEAR_ON_RESET=1
    assign busy_o        = (state_q == SCH_CLEAR);
    assign locked_o      = (state_q == SCH_LOCK);
    assign write_allow_o = (state_q == SCH_RUN);
    assign read_allow_o  = (state_q == SCH_RUN || state_q == SCH_LOCK) && stream_en_i;

    // Natural wrap of clr_addr and the 2-bit phase relies on these
    a_geom: assert property (@(posedge clk_i)
        is_pow2(DEPTH) && ($bits(sched_phase_t) == $clog2(TRB_FRAME_LEN)));

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// Bench for trb_mem_scheduler: zero-fill after reset, vector table for the
// logger slots, host handshake sequences, randomized frames against a
// frame-level reference model, clear-while-pending and async reset mid-frame.
module tb_trb_mem_scheduler;
    import trb_mem_scheduler_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic clear_i = 1'b0, host_lock_i = 1'b0, stream_en_i = 1'b0;
    logic busy_o, locked_o, rw_turn_o, write_allow_o, read_allow_o;

    trb_mem_scheduler_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

    trb_mem_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .host_lock_i  (host_lock_i),
        .stream_en_i  (stream_en_i),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .rw_turn_o    (rw_turn_o),
        .write_allow_o(write_allow_o),
        .read_allow_o (read_allow_o),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    // single-port macro, 1-cycle synchronous read
    logic [WIDTH-1:0] mem [DEPTH] = '{default: 8'hEE};
    logic [WIDTH-1:0] rdata_r = '0;
    always @(posedge clk_i) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_r <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_r;

    // expected frame phase: cycles since reset release, modulo frame length
    int ph_tb;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ph_tb <= 0;
        else         ph_tb <= (ph_tb + 1) % TRB_FRAME_LEN;
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_ph(input int p);
        step();
        for (int i = 0; i < 4 && ph_tb != p; i++) step();
    endtask

    // one host transfer, issued at ph0; the response is due at the next ph0
    task automatic host_frame(input logic we, input logic [3:0] a, input logic [7:0] d,
                              output logic ack, output logic err, output logic [7:0] rd,
                              output logic saw_we);
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        saw_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (bus.mem_we && ph_tb == 2) saw_we = 1'b1;
            step();
        end
        @(negedge clk_i);
        ack = bus.host_ack; err = bus.host_err; rd = bus.host_rdata;
        bus.host_req = 1'b0;
        step();
    endtask

    typedef struct {
        logic       lw;  logic [3:0] wptr; logic [7:0] wd;
        logic       se;  logic [3:0] rptr;
        logic       en;  logic       we;   logic [3:0] addr; logic [7:0] wdata;
        logic       rw;  logic       chk_rd; logic [7:0] rd;
    } vec_t;

    vec_t       tv [8];
    int         nb, nw, werr, nz, early, got, lat, cyc_after;
    logic       a, e, s, mode, lock_nx, se, lw, hreq, hwe, exp_ack, exp_err, exp_isrd;
    logic [3:0] wptr, rptr, haddr;
    logic [7:0] wd, hwd, r, exp_rd;
    logic [7:0] ref_mem [DEPTH];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.log_write = 0; bus.log_wptr = 0; bus.log_wdata = 0; bus.log_rptr = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        stream_en_i = 1'b1;   // must not produce reads while clearing

        // ---- reset state and zero-fill sweep
        #23;
        chk("rst_busy", busy_o, 1);
        chk("rst_outs", {locked_o, rw_turn_o, write_allow_o, read_allow_o,
                         bus.mem_en, bus.mem_we, bus.host_ack, bus.host_err}, 0);
        chk("rst_rdata", bus.host_rdata, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nb = 0; nw = 0; werr = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) break;
            nb++;
            if (rw_turn_o) werr++;
            if (bus.mem_en) begin
                if (!(bus.mem_we && ph_tb == 1 && bus.mem_wdata == 0 && bus.mem_addr == 4'(nw)))
                    werr++;
                nw++;
            end
            @(negedge clk_i);
        end
        chk("clr_busy_cycles", nb, 64);
        chk("clr_writes", nw, 16);
        chk("clr_write_shape", werr, 0);
        chk("clr_exit_phase", ph_tb, 0);
        chk("clr_write_allow", write_allow_o, 1);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 0) nz++;
        chk("clr_mem_zero", nz, 0);
        stream_en_i = 1'b0;
        step(); to_ph(0);

        // ---- logger slot vectors (RUN)
        tv[0] = '{1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[1] = '{1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 8'hA5, 1'b1, 1'b0, 8'h00};
        tv[2] = '{1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[3] = '{1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[4] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tv[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[7] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            bus.log_write = tv[i].lw; bus.log_wptr = tv[i].wptr; bus.log_wdata = tv[i].wd;
            stream_en_i = tv[i].se; bus.log_rptr = tv[i].rptr;
            @(negedge clk_i);
            chk($sformatf("vec%0d_ctl", i), {bus.mem_en, bus.mem_we, rw_turn_o},
                {tv[i].en, tv[i].we, tv[i].rw});
            if (tv[i].en)     chk($sformatf("vec%0d_addr", i), bus.mem_addr, tv[i].addr);
            if (tv[i].we)     chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, tv[i].wdata);
            if (tv[i].chk_rd) chk($sformatf("vec%0d_lrd", i), bus.log_rdata, tv[i].rd);
            step();
        end
        bus.log_write = 0; stream_en_i = 0;

        // ---- host write refused in RUN, accepted in LOCK, read back
        host_frame(1'b1, 4'd3, 8'h3C, a, e, r, s);
        chk("run_wr_ack", a, 1); chk("run_wr_err", e, 1); chk("run_wr_nowe", s, 0);
        to_ph(0);
        host_lock_i = 1'b1;
        to_ph(0);
        chk("lock_entered", locked_o, 1);
        host_frame(1'b1, 4'd3, 8'h3C, a, e, r, s);
        chk("lock_wr_ack", a, 1); chk("lock_wr_err", e, 0); chk("lock_wr_we", s, 1);
        chk("lock_wr_mem", mem[3], 8'h3C);
        to_ph(0);
        host_frame(1'b0, 4'd3, 8'h00, a, e, r, s);
        chk("lock_rd_ack", a, 1); chk("lock_rd_err", e, 0); chk("lock_rd_data", r, 8'h3C);
        host_lock_i = 1'b0;
        to_ph(0); to_ph(0);
        chk("unlock", locked_o, 0);

        // ---- HOST_LOCK_I changes mid-frame take effect at the next ph0
        step();                                   // ph1
        host_lock_i = 1'b1;
        @(negedge clk_i); chk("midlock_ph1", {locked_o, write_allow_o}, 2'b01);
        step(); step();                           // ph3
        @(negedge clk_i); chk("midlock_ph3", {locked_o, write_allow_o}, 2'b01);
        step();                                   // ph0
        @(negedge clk_i); chk("midlock_ph0", {locked_o, write_allow_o}, 2'b10);
        step(); step();                           // ph2
        host_lock_i = 1'b0;
        @(negedge clk_i); chk("midunlock_ph2", {locked_o, write_allow_o}, 2'b10);
        step();                                   // ph3
        @(negedge clk_i); chk("midunlock_ph3", {locked_o, write_allow_o}, 2'b10);
        step();                                   // ph0
        @(negedge clk_i); chk("midunlock_ph0", {locked_o, write_allow_o}, 2'b01);
        step(); to_ph(0);

        // ---- randomized frames vs frame-level reference model
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_mem[5] = 8'hA5; ref_mem[3] = 8'h3C;
        mode = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_isrd = 1'b0; exp_rd = 8'h00;
        for (int f = 0; f < 40; f++) begin
            se = 1'($urandom % 2); lw = 1'($urandom % 2);
            wptr = 4'($urandom); wd = 8'($urandom); rptr = 4'($urandom);
            lock_nx = ($urandom % 4 == 0) ? !host_lock_i : host_lock_i;
            hreq = ($urandom % 3 != 0); hwe = 1'($urandom % 2);
            haddr = 4'($urandom); hwd = 8'($urandom);
            stream_en_i = se; bus.log_write = lw; bus.log_wptr = wptr; bus.log_wdata = wd;
            bus.log_rptr = rptr; host_lock_i = lock_nx;
            bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdata = hwd;
            // ph0
            @(negedge clk_i);
            chk("r_ack", bus.host_ack, exp_ack);
            if (exp_ack) chk("r_err", bus.host_err, exp_err);
            if (exp_ack && exp_isrd) chk("r_hrd", bus.host_rdata, exp_rd);
            chk("r_status", {locked_o, write_allow_o, read_allow_o}, {mode, !mode, se});
            chk("r_ph0", {bus.mem_en, bus.mem_we}, {se, 1'b0});
            if (se) chk("r_ph0_addr", bus.mem_addr, rptr);
            step();
            // ph1
            @(negedge clk_i);
            chk("r_ph1", {rw_turn_o, bus.mem_en, bus.mem_we}, {1'b1, lw && !mode, lw && !mode});
            if (lw && !mode) chk("r_ph1_wr", {bus.mem_addr, bus.mem_wdata}, {wptr, wd});
            if (se) chk("r_lrd", bus.log_rdata, ref_mem[rptr]);
            if (lw && !mode) ref_mem[wptr] = wd;
            step();
            // ph2
            @(negedge clk_i);
            exp_ack = hreq; exp_isrd = hreq && !hwe; exp_err = hreq && hwe && !mode;
            if (hreq && !hwe) begin
                exp_rd = ref_mem[haddr];
                chk("r_ph2_rd", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, haddr});
            end else if (hreq && mode) begin
                chk("r_ph2_wr", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                    {2'b11, haddr, hwd});
                ref_mem[haddr] = hwd;
            end else begin
                chk("r_ph2_idle", bus.mem_en, 0);
            end
            step();
            // ph3
            @(negedge clk_i);
            chk("r_ph3", {bus.mem_en, bus.host_ack}, 2'b00);
            step();
            mode = lock_nx;
        end
        @(negedge clk_i);
        chk("r_ack_last", bus.host_ack, exp_ack);
        if (exp_ack && exp_isrd) chk("r_hrd_last", bus.host_rdata, exp_rd);
        bus.host_req = 0; bus.log_write = 0; stream_en_i = 0; host_lock_i = 0;
        step(); to_ph(0);
        chk("r_back_to_run", locked_o, 0);

        // ---- CLEAR requested in LOCK while a host read is pending
        host_lock_i = 1'b1;
        to_ph(0);
        chk("e_locked", locked_o, 1);
        step(); clear_i = 1'b1;                   // ph1
        step(); clear_i = 1'b0;                   // ph2
        step();                                   // ph3
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd3;
        host_lock_i = 1'b0;
        step();                                   // ph0, now clearing
        bus.host_req = 1'b0;
        @(negedge clk_i);
        chk("e_busy", busy_o, 1);
        nb = 0; early = 0; got = 0; lat = -1; cyc_after = 0; r = 8'hFF;
        for (int i = 0; i < 120; i++) begin
            if (busy_o) begin
                nb++;
                if (bus.host_ack) early++;
                clear_i = (nb == 20);         // ignored during CLEAR
            end else begin
                clear_i = 1'b0;
                if (bus.host_ack) begin
                    got = 1; lat = cyc_after; r = bus.host_rdata;
                    break;
                end
                cyc_after++;
            end
            @(negedge clk_i);
        end
        clear_i = 1'b0;
        chk("e_clear_len", nb, 64);
        chk("e_no_ack_in_clear", early, 0);
        chk("e_ack_seen", got, 1);
        chk("e_ack_latency", lat, 4);
        chk("e_rdata_cleared", r, 8'h00);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (busy_o) nb++;
        end
        chk("e_clear_in_clear_ignored", nb, 0);

        // ---- async reset during ph2 with a host read in flight
        step(); to_ph(0);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd5;
        step(); step();                           // ph2
        chk("f_issue_inflight", bus.mem_en, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("f_rst_outs", {bus.host_ack, bus.host_err, bus.mem_en, bus.mem_we, rw_turn_o,
                           locked_o, write_allow_o, read_allow_o}, 0);
        chk("f_rst_rdata", bus.host_rdata, 0);
        chk("f_rst_busy", busy_o, 1);
        bus.host_req = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        early = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (bus.host_ack) early++;
        end
        chk("f_no_ack_after_rst", early, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
